tile_flash_sequencer: RTL

Plays the stored tile pattern back to the player by sequencing the graphics datapath through highlight/restore draws for each tile in order, with timed hold and gap intervals. Sits between the game control FSM (which supplies the random 18-bit pattern and round length) and the graphics datapath's draw request/done handshake. It owns the datapath only while `busy` is high.

---
 rtl/tile_flash_sequencer_if.sv | 30 +++
 rtl/tile_flash_sequencer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/tile_flash_sequencer_if.sv
// Handshake bundle between the game controller / graphics datapath and the tile flash sequencer.
// Ports: start/abort/seq/length (controller request), draw_req/draw_tile/draw_flash/draw_done
//        (datapath draw handshake), index/busy/done (playback status).
// master = sequencer side, slave = controller + datapath side.
interface tile_flash_sequencer_if;
    // controller -> sequencer
    logic        start;
    logic        abort;
    logic [17:0] seq;
    logic [3:0]  length;
    // datapath -> sequencer
    logic        draw_done;
    // sequencer -> datapath / controller
    logic        draw_req;
    logic [1:0]  draw_tile;
    logic        draw_flash;
    logic [3:0]  index;
    logic        busy;
    logic        done;

    modport master (
        input  start, abort, seq, length, draw_done,
        output draw_req, draw_tile, draw_flash, index, busy, done
    );

    modport slave (
        output start, abort, seq, length, draw_done,
        input  draw_req, draw_tile, draw_flash, index, busy, done
    );
endinterface

// File: rtl/tile_flash_sequencer.sv
// Plays a stored 2-bit-per-tile pattern back through highlight/restore draw requests with timed holds.
// Latency: start sampled at T -> draw_req/busy high after T; each hold lasts ON_CYCLES after draw_done.
// Backpressure: draw_req/tile/flash held until draw_done; start ignored while busy; abort ends with tile restored.
//
// Ports: i_clock, i_reset (async active-high), bus (tile_flash_sequencer_if.master).
// Optional build macro: TILE_FLASH_GAP_EN adds GAP_CYCLES of dark time after each non-final restore draw.
module tile_flash_sequencer #(
    parameter int SEQ_MAX    = 9,
    parameter int ON_CYCLES  = 25000000,
    parameter int GAP_CYCLES = 12500000,
    parameter int CNT_W      = 25
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    tile_flash_sequencer_if.master  bus
);

    localparam logic [3:0]       LP_SEQ_MAX  = 4'(SEQ_MAX);
    localparam logic [CNT_W-1:0] LP_ON_LOAD  = CNT_W'(ON_CYCLES - 1);
    localparam longint           LP_CNT_NEED = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;

    // The interval counter must be able to hold the longest reload value.
    if ((LP_CNT_NEED - 1) > ((longint'(1) << CNT_W) - 1)) begin : g_cnt_w_too_small
        $error("CNT_W too small for ON_CYCLES/GAP_CYCLES");
    end

`ifdef TILE_FLASH_GAP_EN
    localparam logic [CNT_W-1:0] LP_GAP_LOAD = CNT_W'(GAP_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAW_ON,
        S_HOLD_ON,
        S_DRAW_OFF,
`ifdef TILE_FLASH_GAP_EN
        S_GAP,
`endif
        S_FINISH
    } state_t;

    state_t           r_state,  w_state_nxt;
    logic [17:0]      r_seq,    w_seq_nxt;
    logic [3:0]       r_len,    w_len_nxt;
    logic [3:0]       r_index,  w_index_nxt;
    logic [CNT_W-1:0] r_cnt,    w_cnt_nxt;
    logic             r_abort,  w_abort_nxt;

    logic [3:0]  w_len_clamp;
    logic        w_abort;
    logic        w_last;
    logic [17:0] w_seq_shift;

    assign w_len_clamp = (bus.length > LP_SEQ_MAX) ? LP_SEQ_MAX : bus.length;
    // Abort takes effect in the same cycle it is first seen, as well as from the pending flag.
    assign w_abort     = r_abort | bus.abort;
    assign w_last      = (r_index == 4'(r_len - 4'd1));
    assign w_seq_shift = r_seq >> {r_index, 1'b0};

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_seq   <= '0;
            r_len   <= '0;
            r_index <= '0;
            r_cnt   <= '0;
            r_abort <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_seq   <= w_seq_nxt;
            r_len   <= w_len_nxt;
            r_index <= w_index_nxt;
            r_cnt   <= w_cnt_nxt;
            r_abort <= w_abort_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_seq_nxt   = r_seq;
        w_len_nxt   = r_len;
        w_index_nxt = r_index;
        w_cnt_nxt   = r_cnt;
        w_abort_nxt = r_abort | bus.abort;

        case (r_state)
            S_IDLE: begin
                w_abort_nxt = 1'b0;
                if (bus.start) begin
                    w_seq_nxt   = bus.seq;
                    w_len_nxt   = w_len_clamp;
                    w_index_nxt = '0;
                    w_abort_nxt = bus.abort;
                    w_state_nxt = (w_len_clamp == 4'd0) ? S_FINISH : S_DRAW_ON;
                end
            end
            S_DRAW_ON: begin
                if (bus.draw_done) begin
                    if (w_abort) begin
                        // Skip the hold so the tile is restored as soon as possible.
                        w_state_nxt = S_DRAW_OFF;
                    end else begin
                        w_state_nxt = S_HOLD_ON;
                        w_cnt_nxt   = LP_ON_LOAD;
                    end
                end
            end
            S_HOLD_ON: begin
                if (w_abort || (r_cnt == '0)) begin
                    w_state_nxt = S_DRAW_OFF;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt - 1'b1;
                end
            end
            S_DRAW_OFF: begin
                if (bus.draw_done) begin
                    if (w_abort) begin
                        w_state_nxt = S_IDLE;
                        w_abort_nxt = 1'b0;
                    end else if (w_last) begin
                        w_state_nxt = S_FINISH;
                    end else begin
`ifdef TILE_FLASH_GAP_EN
                        w_state_nxt = S_GAP;
                        w_cnt_nxt   = LP_GAP_LOAD;
`else
                        w_state_nxt = S_DRAW_ON;
                        w_index_nxt = r_index + 4'd1;
`endif
                    end
                end
            end
`ifdef TILE_FLASH_GAP_EN
            S_GAP: begin
                if (w_abort) begin
                    w_state_nxt = S_IDLE;
                    w_abort_nxt = 1'b0;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == '0) begin
                    w_state_nxt = S_DRAW_ON;
                    w_index_nxt = r_index + 4'd1;
                end else begin
                    w_cnt_nxt   = r_cnt - 1'b1;
                end
            end
`endif
            S_FINISH: begin
                w_state_nxt = S_IDLE;
                w_abort_nxt = 1'b0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_abort_nxt = 1'b0;
            end
        endcase
    end

    // Outputs decode straight from registered state so reset clears them asynchronously.
    assign bus.draw_req   = (r_state == S_DRAW_ON) || (r_state == S_DRAW_OFF);
    assign bus.draw_flash = (r_state == S_DRAW_ON);
    assign bus.draw_tile  = w_seq_shift[1:0];
    assign bus.index      = r_index;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.done       = (r_state == S_FINISH);

endmodule
